// File: rtl/mem_read_burst_if.sv
// Burst-read bus: command/status, memory read port and consumer valid/ready stream.
// The DUT side uses the slave modport; the environment side uses master.
interface mem_read_burst_if #(
  parameter int N  = 63,
  parameter int AW = 8,
  parameter int LW = 8
);
  logic          start;
  logic [AW-1:0] base;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [N:0]    mem_rdata;
  logic          rd_valid;
  logic [N:0]    rd_data;
  logic          rd_ready;

  modport slave (
    input  start, base, len, mem_rdata, rd_ready,
    output busy, done, mem_re, mem_addr, rd_valid, rd_data
  );

  modport master (
    output start, base, len, mem_rdata, rd_ready,
    input  busy, done, mem_re, mem_addr, rd_valid, rd_data
  );
endinterface

// File: rtl/mem_read_burst.sv
// Burst reader: issues LEN reads from a fixed-latency memory starting at BASE and
// streams the returned words through a DEPTH-entry FIFO to a valid/ready consumer.
module mem_read_burst #(
  parameter int N     = 63,
  parameter int AW    = 8,
  parameter int LW    = 8,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_read_burst_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, cur_addr;
  logic [LW-1:0] rem_q, rem_d, cur_rem;
  logic          mem_re_q, mem_re_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [LAT-1:0] trk_q, trk_d;
  logic [N:0]    fifo_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          push, pop, credit, issue;
  int unsigned   occ;

  assign push = trk_q[LAT-1];
  assign pop  = (cnt_q != '0) && bus.rd_ready;

  // Occupancy after this edge: reads in flight (incl. the one on the bus now) plus
  // FIFO words, minus the word leaving this cycle. A new issue fits only below DEPTH.
  always_comb begin
    occ = 32'(mem_re_q) + 32'(cnt_q);
    for (int unsigned i = 0; i < LAT; i++) occ = occ + 32'(trk_q[i]);
    if (pop) occ = occ - 32'd1;
    credit = occ < 32'(DEPTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            issue   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (rem_q == '0) begin
          state_d = S_DRAIN;
        end else if (credit) begin
          issue = 1'b1;
          if (rem_q == LW'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!mem_re_q && trk_q == '0 && cnt_q == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != S_IDLE);
    bus.done = (state_q == S_DONE);
  end

  // The first read is launched from IDLE so mem_re is on the bus the cycle after start.
  always_comb begin
    cur_addr   = (state_q == S_IDLE) ? bus.base : addr_q;
    cur_rem    = (state_q == S_IDLE) ? bus.len  : rem_q;
    mem_re_d   = issue;
    mem_addr_d = mem_addr_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    if (issue) begin
      mem_addr_d = cur_addr;
      addr_d     = cur_addr + 1'b1;
      rem_d      = cur_rem - 1'b1;
    end
    trk_d = (trk_q << 1) | LAT'(mem_re_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      rem_q      <= '0;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
      trk_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      mem_re_q   <= mem_re_d;
      mem_addr_q <= mem_addr_d;
      trk_q      <= trk_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= bus.mem_rdata;
  end

  assign bus.mem_re   = mem_re_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.rd_valid = (cnt_q != '0);
  assign bus.rd_data  = (cnt_q != '0) ? fifo_q[rptr_q] : '0;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && cnt_q == CW'(DEPTH)));
endmodule

// File: tb/tb_mem_read_burst.sv
// Directed bench for mem_read_burst with a LAT=2 memory model returning {56'h0, addr}.
module tb_mem_read_burst;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_read_burst_if #(.N(63), .AW(8), .LW(8)) bus ();

  mem_read_burst #(.N(63), .AW(8), .LW(8), .LAT(2), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic       v1 = 1'b0, v2 = 1'b0;
  logic [7:0] a1 = '0, a2 = '0;
  always @(posedge clk) begin
    v1 <= bus.mem_re;  a1 <= bus.mem_addr;
    v2 <= v1;          a2 <= a1;
  end
  assign bus.mem_rdata = v2 ? {56'h0, a2} : 64'hDEAD_BEEF_0BAD_F00D;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_re = 0, n_done = 0, n_valid = 0, zero_viol = 0;
  logic [63:0] got[$];
  logic [63:0] addr_log[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_re) begin n_re++; addr_log.push_back(64'(bus.mem_addr)); end
      if (bus.done) n_done++;
      if (bus.rd_valid) n_valid++;
      if (bus.rd_valid && bus.rd_ready) got.push_back(bus.rd_data);
      if (!bus.rd_valid && bus.rd_data != '0) zero_viol++;
    end
  end

  task automatic clear_logs();
    n_re = 0; n_done = 0; n_valid = 0;
    got.delete(); addr_log.delete();
  endtask

  task automatic start_burst(input logic [7:0] b, input logic [7:0] l);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base = b; bus.len = l;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string tag, input logic [7:0] first, input int n);
    logic [7:0] a;
    check({tag, " words"}, 64'(got.size()), 64'(n));
    check({tag, " issues"}, 64'(addr_log.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      a = first + 8'(i);
      check($sformatf("%s data%0d", tag, i), (i < got.size()) ? got[i] : '1, {56'h0, a});
      check($sformatf("%s addr%0d", tag, i), (i < addr_log.size()) ? addr_log[i] : '1, 64'(a));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " busy"},     64'(bus.busy),     64'd0);
    check({tag, " done"},     64'(bus.done),     64'd0);
    check({tag, " mem_re"},   64'(bus.mem_re),   64'd0);
    check({tag, " mem_addr"}, 64'(bus.mem_addr), 64'd0);
    check({tag, " rd_valid"}, 64'(bus.rd_valid), 64'd0);
    check({tag, " rd_data"},  bus.rd_data,       64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.base = '0; bus.len = '0; bus.rd_ready = 1'b1;
    #3;
    check_outputs_zero("reset");
    step(2);
    rst = 1'b0;

    // Test 1: cycle-accurate base=0x10 len=4
    clear_logs();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base = 8'h10; bus.len = 8'd4; bus.rd_ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      check($sformatf("t1 mem_re c%0d", c), 64'(bus.mem_re), 64'(c >= 1 && c <= 4));
      if (c >= 1 && c <= 4)
        check($sformatf("t1 mem_addr c%0d", c), 64'(bus.mem_addr), 64'(8'h10 + c - 1));
      check($sformatf("t1 rd_valid c%0d", c), 64'(bus.rd_valid), 64'(c >= 4 && c <= 7));
      check($sformatf("t1 rd_data c%0d", c), bus.rd_data,
            (c >= 4 && c <= 7) ? 64'(8'h10 + c - 4) : 64'd0);
      check($sformatf("t1 done c%0d", c), 64'(bus.done), 64'(c == 9));
      check($sformatf("t1 busy c%0d", c), 64'(bus.busy), 64'(c >= 1 && c <= 9));
      @(posedge clk); #1;
      bus.start = 1'b0;
    end

    // Test 2: backpressure stalls issue at FIFO depth
    clear_logs();
    bus.rd_ready = 1'b0;
    start_burst(8'h00, 8'd8);
    step(12);
    check("t2 stall issues", 64'(n_re), 64'd4);
    check("t2 stall mem_re", 64'(bus.mem_re), 64'd0);
    check("t2 stall valid", 64'(bus.rd_valid), 64'd1);
    check("t2 stall busy", 64'(bus.busy), 64'd1);
    check("t2 stall no done", 64'(n_done), 64'd0);
    bus.rd_ready = 1'b1;
    wait_done("t2 done seen", 60);
    step(2);
    check("t2 done count", 64'(n_done), 64'd1);
    check_seq("t2", 8'h00, 8);

    // Test 3: zero-length burst
    clear_logs();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base = 8'h33; bus.len = 8'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("t3 done next cycle", 64'(bus.done), 64'd1);
    step(4);
    check("t3 no mem_re", 64'(n_re), 64'd0);
    check("t3 no valid", 64'(n_valid), 64'd0);
    check("t3 done count", 64'(n_done), 64'd1);
    check("t3 idle", 64'(bus.busy), 64'd0);

    // Test 4: address wrap
    clear_logs();
    start_burst(8'hFE, 8'd4);
    wait_done("t4 done seen", 40);
    step(2);
    check_seq("t4", 8'hFE, 4);

    // Test 5: reset mid-burst, then a clean burst
    clear_logs();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base = 8'h10; bus.len = 8'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    step(2);
    rst = 1'b1;
    #1;
    check_outputs_zero("t5 async");
    step(2);
    rst = 1'b0;
    step(3);
    check_outputs_zero("t5 after");
    clear_logs();
    start_burst(8'h40, 8'd3);
    wait_done("t5 done seen", 40);
    step(2);
    check_seq("t5", 8'h40, 3);

    // Test 6: starts while busy (incl. DONE cycle) are ignored
    clear_logs();
    @(posedge clk); #1;
    for (int c = 0; c <= 15; c++) begin
      bus.start = 1'b0;
      if (c == 0) begin bus.start = 1'b1; bus.base = 8'h20; bus.len = 8'd4; end
      if (c == 2) begin bus.start = 1'b1; bus.base = 8'h80; bus.len = 8'd2; end
      if (c == 9) begin bus.start = 1'b1; bus.base = 8'h90; bus.len = 8'd1; end
      @(negedge clk);
      if (c == 9) check("t6 done c9", 64'(bus.done), 64'd1);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    check("t6 done count", 64'(n_done), 64'd1);
    check("t6 idle at end", 64'(bus.busy), 64'd0);
    check_seq("t6", 8'h20, 4);

    check("rd_data zero when invalid", 64'(zero_viol), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
